// File: rtl/multicycle_alu.sv
// Execute-stage ALU: registered single-cycle ADD/SUB/AND/SLT and an iterative
// shift-add multiplier that stalls the pipeline through busy_o.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready; start_i issues an op, single-cycle ops finish here
// ST_MUL  | shift-add multiply running, one step per clock, busy_o=1
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [5:0]       Funct_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             valid_o,
    output logic             illegal_o,
    output logic             busy_o
);

    localparam logic [5:0] FUNCT_ADD = 6'b001001;
    localparam logic [5:0] FUNCT_SUB = 6'b001010;
    localparam logic [5:0] FUNCT_AND = 6'b010001;
    localparam logic [5:0] FUNCT_SLT = 6'b100001;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;
    localparam int         CW        = $clog2(WIDTH + 1);

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] result_next;
    logic             zero_next, valid_next, illegal_next;
    logic [WIDTH-1:0] acc, acc_next;
    logic [WIDTH-1:0] mcand, mcand_next;
    logic [WIDTH-1:0] mplier, mplier_next;
    logic [CW-1:0]    steps, steps_next;
    logic [WIDTH-1:0] step_sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            result_o  <= '0;
            zero_o    <= 1'b0;
            valid_o   <= 1'b0;
            illegal_o <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            steps     <= '0;
        end else begin
            state     <= state_next;
            result_o  <= result_next;
            zero_o    <= zero_next;
            valid_o   <= valid_next;
            illegal_o <= illegal_next;
            acc       <= acc_next;
            mcand     <= mcand_next;
            mplier    <= mplier_next;
            steps     <= steps_next;
        end
    end

    assign busy_o   = (state == ST_MUL);
    assign step_sum = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_next   = state;
        result_next  = result_o;
        zero_next    = zero_o;
        valid_next   = 1'b0;
        illegal_next = 1'b0;
        acc_next     = acc;
        mcand_next   = mcand;
        mplier_next  = mplier;
        steps_next   = steps;

        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    case (Funct_i)
                        FUNCT_ADD: begin
                            result_next = src1_i + src2_i;
                            valid_next  = 1'b1;
                        end
                        FUNCT_SUB: begin
                            result_next = src1_i - src2_i;
                            valid_next  = 1'b1;
                        end
                        FUNCT_AND: begin
                            result_next = src1_i & src2_i;
                            valid_next  = 1'b1;
                        end
                        FUNCT_SLT: begin
                            result_next = {{(WIDTH-1){1'b0}},
                                           ($signed(src1_i) < $signed(src2_i))};
                            valid_next  = 1'b1;
                        end
                        FUNCT_MUL: begin
                            acc_next    = '0;
                            mcand_next  = src1_i;
                            mplier_next = src2_i;
                            steps_next  = CW'(WIDTH);
                            state_next  = ST_MUL;
                        end
                        default: begin
                            result_next  = '0;
                            valid_next   = 1'b1;
                            illegal_next = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                acc_next    = step_sum;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                steps_next  = steps - CW'(1);
                // Last step: publish the final partial sum directly.
                if (steps == CW'(1)) begin
                    result_next = step_sum;
                    valid_next  = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (valid_next) begin
            zero_next = (result_next == '0);
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: fixed vector table, randomized ops
// against an arithmetic reference model, and hand-written multi-cycle sequences.
module tb_multicycle_alu;

    localparam logic [5:0] F_ADD = 6'b001001;
    localparam logic [5:0] F_SUB = 6'b001010;
    localparam logic [5:0] F_AND = 6'b010001;
    localparam logic [5:0] F_SLT = 6'b100001;
    localparam logic [5:0] F_MUL = 6'b011000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [31:0] result;
    logic        zero, valid, illegal, busy;

    int total = 0;
    int bad   = 0;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .Funct_i   (funct),
        .src1_i    (src1),
        .src2_i    (src2),
        .result_o  (result),
        .zero_o    (zero),
        .valid_o   (valid),
        .illegal_o (illegal),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ill;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the arithmetic meaning of each Funct code.
    function automatic void ref_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ill);
        longint unsigned prod;
        ill = 1'b0;
        case (f)
            F_ADD:   r = a + b;
            F_SUB:   r = a - b;
            F_AND:   r = a & b;
            F_SLT:   r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            F_MUL: begin
                prod = longint'(a) * longint'(b);
                r    = prod[31:0];
            end
            default: begin
                r   = 32'd0;
                ill = 1'b1;
            end
        endcase
    endfunction

    // Drive one issue cycle, then scramble inputs to show they were captured.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        funct = f;
        src1  = a;
        src2  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct = 6'($urandom);
        src1  = $urandom;
        src2  = $urandom;
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic eil,
                          input bit idle);
        int cyc;
        issue(f, a, b);
        cyc = 0;
        if (f == F_MUL) begin
            check({name, " busy"}, 64'(busy), 64'd1);
            while (valid !== 1'b1 && cyc < 40) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check({name, " latency"}, 64'(cyc), 64'd32);
        end
        check({name, " valid"}, 64'(valid), 64'd1);
        check({name, " result"}, 64'(result), 64'(er));
        check({name, " zero"}, 64'(zero), 64'(er == 32'd0));
        check({name, " illegal"}, 64'(illegal), 64'(eil));
        check({name, " busy_done"}, 64'(busy), 64'd0);
        if (idle) begin
            @(posedge clk);
            #1;
            check({name, " valid_drop"}, 64'(valid), 64'd0);
            check({name, " illegal_drop"}, 64'(illegal), 64'd0);
            check({name, " result_hold"}, 64'(result), 64'(er));
        end
    endtask

    vec_t vecs[10];

    initial begin
        logic [5:0]  f;
        logic [31:0] a, b, er, vres;
        logic        eil;
        int          busy_cnt, vcnt, vcyc;
        logic [5:0]  fsel[6];

        vecs[0] = '{F_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[1] = '{F_SLT, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0001, 1'b0};
        vecs[2] = '{F_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};
        vecs[3] = '{F_MUL, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1'b0};
        vecs[4] = '{F_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0};
        vecs[5] = '{6'b111111, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000, 1'b1};
        vecs[6] = '{F_SLT, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0000, 1'b0};
        vecs[7] = '{F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[8] = '{F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
        vecs[9] = '{F_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0};

        // Reset with start held high must not produce a result.
        rst   = 1'b1;
        start = 1'b1;
        funct = F_ADD;
        src1  = 32'd1;
        src2  = 32'd1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst valid", 64'(valid), 64'd0);
            check("rst result", 64'(result), 64'd0);
            check("rst zero", 64'(zero), 64'd0);
            check("rst illegal", 64'(illegal), 64'd0);
            check("rst busy", 64'(busy), 64'd0);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                   vecs[i].r, vecs[i].ill, 1'b1);
        end

        // Illegal followed by a zero-bubble AND.
        issue(6'b111111, 32'hDEAD_BEEF, 32'h1234_5678);
        check("ill valid", 64'(valid), 64'd1);
        check("ill flag", 64'(illegal), 64'd1);
        check("ill result", 64'(result), 64'd0);
        check("ill zero", 64'(zero), 64'd1);
        run_op("b2b_and", F_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b1);

        // MUL with a stray ADD start while busy; only the MUL may complete.
        run_op("pre_add", F_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);
        issue(F_MUL, 32'h0001_2345, 32'h0000_0100);
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        vcnt = 0;
        vcyc = 0;
        vres = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 5) begin
                start = 1'b1;
                funct = F_ADD;
                src1  = 32'd1;
                src2  = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (busy === 1'b1) busy_cnt++;
            if (i == 1) check("mul result_hold", 64'(result), 64'd2);
            if (valid === 1'b1) begin
                vcnt++;
                vcyc = i;
                vres = result;
            end
        end
        start = 1'b0;
        check("mul busy_cycles", 64'(busy_cnt), 64'd32);
        check("mul valid_count", 64'(vcnt), 64'd1);
        check("mul valid_cycle", 64'(vcyc), 64'd32);
        check("mul result", 64'(vres), 64'h0123_4500);

        // MUL aborted by reset after 10 steps.
        issue(F_MUL, 32'd7, 32'd9);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort valid", 64'(valid), 64'd0);
        check("abort result", 64'(result), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        vcnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid === 1'b1) vcnt++;
        end
        check("abort no_valid", 64'(vcnt), 64'd0);
        run_op("post_abort_add", F_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1);

        // MUL completion followed directly by an issue in the valid cycle.
        run_op("mul_b2b", F_MUL, 32'd1000, 32'd3000, 32'd3000000, 1'b0, 1'b0);
        run_op("after_mul_sub", F_SUB, 32'd10, 32'd10, 32'd0, 1'b0, 1'b1);

        // Randomized ops against the reference model.
        fsel[0] = F_ADD;
        fsel[1] = F_SUB;
        fsel[2] = F_AND;
        fsel[3] = F_SLT;
        fsel[4] = F_MUL;
        for (int i = 0; i < 30; i++) begin
            fsel[5] = 6'($urandom);
            f = fsel[$urandom_range(0, 5)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            ref_alu(f, a, b, er, eil);
            run_op($sformatf("rand%0d f=%b", i, f), f, a, b, er, eil, bit'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
